aq_key_matrix: RTL and testbench

PS/2-scancode to Aquarius keyboard-matrix converter for the Aquarius MiST core. It consumes the byte stream and strobe produced by the `keyboard` PS/2 receiver and tracks the pressed/released state of the 8×8 Aquarius key matrix. It returns the active-low column byte for the rows the CPU selects through `cpu_addr[15:8]`. Its output feeds Pla1's key port in place of the current matrix logic.

---
 rtl/aq_kbd_pkg.sv | 93 +++++++++
 rtl/aq_key_decode.sv | 12 +
 rtl/aq_key_matrix.sv | 115 +++++++++++
 tb/tb_aq_key_matrix.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/aq_kbd_pkg.sv
// aq_kbd_pkg: decoder states, PS/2 prefix/control bytes and the set-2 to Aquarius matrix table.
// Cells are written in octal as row,col so 6'o73 reads as row 7, column 3.
package aq_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } kbd_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_DEL    = 8'h71;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t key_map(input logic ext, input logic [7:0] code);
        logic       hit;
        logic [5:0] rc;
        hit = 1'b1;
        rc  = 6'o00;
        case ({ext, code})
            9'h055: rc = 6'o00;
            9'h066: rc = 6'o01;
            9'h171: rc = 6'o01;
            9'h052: rc = 6'o02;
            9'h05A: rc = 6'o03;
            9'h04C: rc = 6'o04;
            9'h049: rc = 6'o05;
            9'h071: rc = 6'o05;
            9'h04E: rc = 6'o10;
            9'h04A: rc = 6'o11;
            9'h045: rc = 6'o12;
            9'h04D: rc = 6'o13;
            9'h04B: rc = 6'o14;
            9'h041: rc = 6'o15;
            9'h046: rc = 6'o20;
            9'h044: rc = 6'o21;
            9'h042: rc = 6'o22;
            9'h03A: rc = 6'o23;
            9'h031: rc = 6'o24;
            9'h03B: rc = 6'o25;
            9'h03E: rc = 6'o30;
            9'h043: rc = 6'o31;
            9'h03D: rc = 6'o32;
            9'h03C: rc = 6'o33;
            9'h033: rc = 6'o34;
            9'h032: rc = 6'o35;
            9'h036: rc = 6'o40;
            9'h035: rc = 6'o41;
            9'h034: rc = 6'o42;
            9'h02A: rc = 6'o43;
            9'h021: rc = 6'o44;
            9'h02B: rc = 6'o45;
            9'h02E: rc = 6'o50;
            9'h02C: rc = 6'o51;
            9'h025: rc = 6'o52;
            9'h02D: rc = 6'o53;
            9'h023: rc = 6'o54;
            9'h022: rc = 6'o55;
            9'h026: rc = 6'o60;
            9'h024: rc = 6'o61;
            9'h01B: rc = 6'o62;
            9'h01A: rc = 6'o63;
            9'h029: rc = 6'o64;
            9'h01C: rc = 6'o65;
            9'h01E: rc = 6'o70;
            9'h01D: rc = 6'o71;
            9'h016: rc = 6'o72;
            9'h015: rc = 6'o73;
            9'h012: rc = 6'o74;
            9'h059: rc = 6'o74;
            9'h014: rc = 6'o75;
            9'h114: rc = 6'o75;
            default: hit = 1'b0;
        endcase
        return key_pos_t'({hit, rc});
    endfunction

endpackage

// File: rtl/aq_key_decode.sv
// aq_key_decode: combinational scancode-to-matrix-cell lookup, isolated so the table can be swapped.
module aq_key_decode
    import aq_kbd_pkg::*;
(
    input  logic       i_ext,
    input  logic [7:0] i_code,
    output key_pos_t   o_key
);

    assign o_key = key_map(i_ext, i_code);

endmodule

// File: rtl/aq_key_matrix.sv
// aq_key_matrix: PS/2 set-2 byte stream to Aquarius 8x8 key matrix with registered column output.
// Define AQ_KEY_RESET_EN to build the Ctrl+Delete CPU reset pulse.
module aq_key_matrix
    import aq_kbd_pkg::*;
#(
    parameter int unsigned RESET_PULSE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       matrix_clear,
    input  logic [7:0] row_sel,
    output logic [7:0] key_data,
    output logic       reset_req
);

    if (RESET_PULSE < 1 || RESET_PULSE > 255) begin : g_bad_pulse
        $error("RESET_PULSE must be in 1..255");
    end

    kbd_state_t r_state, w_next;
    logic [2:0]  r_skip_cnt;
    logic [63:0] r_pressed;
    logic [7:0]  r_key_data, w_col;
    logic        w_ext, w_make, w_brk, w_clear;
    key_pos_t    w_key;

    assign w_clear = reset | matrix_clear;
    assign w_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

    aq_key_decode u_decode (
        .i_ext (w_ext),
        .i_code(scan_code),
        .o_key (w_key)
    );

    always_comb begin
        w_next = r_state;
        w_make = 1'b0;
        w_brk  = 1'b0;
        if (scan_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_next = scan_code == SC_EXT   ? ST_EXT :
                             scan_code == SC_BRK   ? ST_BRK :
                             scan_code == SC_PAUSE ? ST_PAUSE : ST_IDLE;
                    w_make = !(scan_code inside {SC_EXT, SC_BRK, SC_PAUSE, SC_BAT, SC_ACK, SC_ECHO, SC_RESEND});
                end
                ST_EXT: begin
                    w_next = scan_code == SC_BRK ? ST_EXT_BRK : ST_IDLE;
                    w_make = scan_code != SC_BRK;
                end
                ST_BRK, ST_EXT_BRK: begin
                    w_next = ST_IDLE;
                    w_brk  = 1'b1;
                end
                ST_PAUSE: w_next = r_skip_cnt <= 3'd1 ? ST_IDLE : ST_PAUSE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_state <= w_clear ? ST_IDLE : w_next;
        if (w_clear)
            r_skip_cnt <= 3'd0;
        else if (scan_valid && r_state == ST_IDLE && scan_code == SC_PAUSE)
            r_skip_cnt <= PAUSE_SKIP;
        else if (scan_valid && r_state == ST_PAUSE && r_skip_cnt != 3'd0)
            r_skip_cnt <= r_skip_cnt - 3'd1;
        if (w_clear)
            r_pressed <= '0;
        else if (w_key.hit && (w_make || w_brk))
            r_pressed[{w_key.row, w_key.col}] <= w_make;
    end

    always_comb begin
        w_col = '0;
        for (int r = 0; r < 8; r++)
            if (!row_sel[r]) w_col = w_col | r_pressed[r*8 +: 8];
    end

    always_ff @(posedge clk)
        r_key_data <= reset ? 8'hFF : ~w_col;

    assign key_data = r_key_data;

`ifdef AQ_KEY_RESET_EN
    logic       r_lctrl;
    logic [7:0] r_pulse_cnt;
    logic       w_trigger;

    // Only the non-extended Ctrl counts; right Ctrl shares the cell but must not arm the reset.
    assign w_trigger = !matrix_clear && w_make && w_ext && scan_code == SC_DEL && r_lctrl;

    always_ff @(posedge clk) begin
        if (w_clear)
            r_lctrl <= 1'b0;
        else if ((w_make || w_brk) && !w_ext && scan_code == SC_LCTRL)
            r_lctrl <= w_make;
        if (reset)
            r_pulse_cnt <= 8'd0;
        else if (w_trigger)
            r_pulse_cnt <= 8'(RESET_PULSE);
        else if (r_pulse_cnt != 8'd0)
            r_pulse_cnt <= r_pulse_cnt - 8'd1;
    end

    assign reset_req = r_pulse_cnt != 8'd0;
`else
    assign reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_aq_key_matrix.sv
// tb_aq_key_matrix: directed vector table plus hand sequences for prefixes, pause, clear and reset pulse.
module tb_aq_key_matrix;

    logic       clk = 1'b0;
    logic       reset, scan_valid, matrix_clear, reset_req;
    logic [7:0] scan_code, row_sel, key_data;
    int         checks = 0;
    int         errors = 0;
    int         n;

    always #5 clk = ~clk;

    aq_key_matrix #(.RESET_PULSE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .matrix_clear(matrix_clear),
        .row_sel     (row_sel),
        .key_data    (key_data),
        .reset_req   (reset_req)
    );

    typedef struct {
        logic [7:0] code;
        logic [7:0] rs;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
    endtask

    task automatic clear_matrix();
        matrix_clear = 1'b1;
        tick();
        matrix_clear = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic count_req(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (reset_req) cnt++;
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{8'h5A, 8'hFE, 8'hF7};
        vecs[1]  = '{8'hF0, 8'hFE, 8'hF7};
        vecs[2]  = '{8'h5A, 8'hFE, 8'hFF};
        vecs[3]  = '{8'h1C, 8'hBF, 8'hDF};
        vecs[4]  = '{8'h12, 8'h7F, 8'hEF};
        vecs[5]  = '{8'h14, 8'h7F, 8'hCF};
        vecs[6]  = '{8'h5A, 8'h7E, 8'hC7};
        vecs[7]  = '{8'hF0, 8'h7E, 8'hC7};
        vecs[8]  = '{8'h59, 8'h7E, 8'hD7};
        vecs[9]  = '{8'hE0, 8'hFF, 8'hFF};
        vecs[10] = '{8'h71, 8'hFE, 8'hF5};
        vecs[11] = '{8'hE0, 8'hFE, 8'hF5};
        vecs[12] = '{8'hF0, 8'hFE, 8'hF5};
        vecs[13] = '{8'h71, 8'hFE, 8'hF7};
        vecs[14] = '{8'h71, 8'hFE, 8'hD7};
        vecs[15] = '{8'hAA, 8'hFE, 8'hD7};
        vecs[16] = '{8'hFA, 8'hFE, 8'hD7};
        vecs[17] = '{8'h07, 8'hFE, 8'hD7};
        vecs[18] = '{8'hF0, 8'hBF, 8'hDF};
        vecs[19] = '{8'h1C, 8'hBF, 8'hFF};
        vecs[20] = '{8'hF0, 8'h7F, 8'hDF};
        vecs[21] = '{8'h16, 8'h7F, 8'hDF};
        vecs[22] = '{8'h00, 8'h00, 8'hD7};

        reset = 1'b1; scan_valid = 1'b0; matrix_clear = 1'b0; scan_code = 8'h00; row_sel = 8'hFF;
        tick(); tick();
        reset = 1'b0; row_sel = 8'hFE;
        tick();
        check("reset_key_data", key_data, 8'hFF);
        check("reset_req_reset", reset_req, 1'b0);

        send(8'h5A);
        check("enter_latency_n1", key_data, 8'hFF);
        tick();
        check("enter_make", key_data, 8'hF7);
        send(8'hF0); send(8'h5A); tick();
        check("enter_break", key_data, 8'hFF);

        send(8'h5A); send(8'h12);
        row_sel = 8'h7E; tick();
        check("enter_shift_7e", key_data, 8'hE7);
        row_sel = 8'hFF; tick();
        check("no_row_ff", key_data, 8'hFF);
        clear_matrix();

        for (int i = 0; i < 23; i++) begin
            row_sel = vecs[i].rs;
            send(vecs[i].code);
            tick();
            check($sformatf("vec%0d", i), key_data, vecs[i].exp);
        end
        clear_matrix();

        row_sel = 8'h7E;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h5A);
        tick();
        check("pause_then_enter", key_data, 8'hF7);
        row_sel = 8'h7F; tick();
        check("pause_ctrl_unset", key_data, 8'hFF);
        clear_matrix();

        row_sel = 8'hFE;
        send(8'hE0);
        scan_code = 8'h5A; scan_valid = 1'b1; matrix_clear = 1'b1;
        tick();
        scan_valid = 1'b0; matrix_clear = 1'b0;
        tick();
        check("clear_beats_valid", key_data, 8'hFF);
        send(8'h5A); tick();
        check("after_clear_enter", key_data, 8'hF7);
        send(8'hE0);
        scan_code = 8'h71; scan_valid = 1'b1; matrix_clear = 1'b1;
        tick();
        scan_valid = 1'b0; matrix_clear = 1'b0;
        send(8'h71); tick();
        check("clear_drops_ext", key_data, 8'hDF);

        clear_matrix();
        send(8'hE0);
        reset = 1'b1; tick(); reset = 1'b0;
        send(8'h71); tick();
        check("reset_drops_ext", key_data, 8'hDF);

        clear_matrix();
        send(8'h14); send(8'hE0); send(8'h71);
        count_req(n);
`ifdef AQ_KEY_RESET_EN
        check("reset_pulse_len", n, 16);
        send(8'hE0); send(8'h71);
        repeat (5) tick();
        send(8'hE0); send(8'h71);
        count_req(n);
        check("retrigger_len", n, 16);
        send(8'hE0); send(8'h71); tick();
        check("pulse_active", reset_req, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("reset_kills_pulse", reset_req, 1'b0);
`else
        check("reset_req_tied", n, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
